// File: rtl/directory_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : directory_req_arbiter
// Purpose  : Request front end for the even/odd directory banks. Each of the
//            three sources (I$, D$, MEM) feeds a private FIFO. The FIFO head
//            is steered to a bank by line parity (addr[4]) and each bank runs
//            its own round-robin arbiter. The winning entry is registered onto
//            that bank's request port. The banks never apply backpressure.
// Ports    : clk, rst (asynchronous, active-low)
//            <s>_req_valid/ready/addr/data/op/dest   s = ic, dc, mem
//            <b>_addr/data/op/src/dest_out           b = even, odd
//            <b>_op_out == 0 means "no request this cycle".
// Config   : DIR_ARB_MEM_PRIO_EN - when defined, a mem candidate always wins
//            both bank arbiters. ic/dc round-robin between themselves and the
//            pointer never records a mem grant.
// Revision : 1.0 - initial release
// ============================================================================
module directory_req_arbiter #(
    parameter int CL_SIZE    = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               ic_req_valid,
    output logic               ic_req_ready,
    input  logic [31:0]        ic_req_addr,
    input  logic [CL_SIZE-1:0] ic_req_data,
    input  logic [2:0]         ic_req_op,
    input  logic [1:0]         ic_req_dest,

    input  logic               dc_req_valid,
    output logic               dc_req_ready,
    input  logic [31:0]        dc_req_addr,
    input  logic [CL_SIZE-1:0] dc_req_data,
    input  logic [2:0]         dc_req_op,
    input  logic [1:0]         dc_req_dest,

    input  logic               mem_req_valid,
    output logic               mem_req_ready,
    input  logic [31:0]        mem_req_addr,
    input  logic [CL_SIZE-1:0] mem_req_data,
    input  logic [2:0]         mem_req_op,
    input  logic [1:0]         mem_req_dest,

    output logic [31:0]        even_addr_out,
    output logic [CL_SIZE-1:0] even_data_out,
    output logic [2:0]         even_op_out,
    output logic [1:0]         even_src_out,
    output logic [1:0]         even_dest_out,

    output logic [31:0]        odd_addr_out,
    output logic [CL_SIZE-1:0] odd_data_out,
    output logic [2:0]         odd_op_out,
    output logic [1:0]         odd_src_out,
    output logic [1:0]         odd_dest_out
);

    localparam int NSRC  = 3;
    localparam int NBANK = 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Source indices; the source code driven on <b>_src_out is index + 1.
    localparam logic [1:0] C_IDX_IC  = 2'd0;
    localparam logic [1:0] C_IDX_DC  = 2'd1;
    localparam logic [1:0] C_IDX_MEM = 2'd2;
    localparam logic [2:0] C_OP_NOOP = 3'd0;

    typedef struct packed {
        logic [31:0]        addr;
        logic [CL_SIZE-1:0] data;
        logic [2:0]         op;
        logic [1:0]         dest;
    } req_entry_t;

    // ------------------------------------------------------------------
    // Source-side signals
    // ------------------------------------------------------------------
    logic [NSRC-1:0]   in_valid;
    logic [NSRC-1:0]   in_ready;
    logic [NSRC-1:0]   push;
    logic [NSRC-1:0]   pop;
    logic [NSRC-1:0]   nonempty;
    logic [NSRC-1:0]   head_odd;
    req_entry_t        in_entry   [NSRC];
    req_entry_t        head_entry [NSRC];

    req_entry_t        fifo_mem_q [NSRC][FIFO_DEPTH];
    logic [CNT_W-1:0]  count_q [NSRC];
    logic [CNT_W-1:0]  count_d [NSRC];
    logic [PTR_W-1:0]  rptr_q  [NSRC];
    logic [PTR_W-1:0]  rptr_d  [NSRC];
    logic [PTR_W-1:0]  wptr_q  [NSRC];
    logic [PTR_W-1:0]  wptr_d  [NSRC];

    // ------------------------------------------------------------------
    // Bank-side signals (index 0 = even, 1 = odd)
    // ------------------------------------------------------------------
    logic [NSRC-1:0]    cand      [NBANK];
    logic               gnt_any   [NBANK];
    logic [1:0]         gnt_idx   [NBANK];
    logic [1:0]         rr_ptr_q  [NBANK];
    logic [1:0]         rr_ptr_d  [NBANK];

    logic [31:0]        out_addr_q [NBANK];
    logic [31:0]        out_addr_d [NBANK];
    logic [CL_SIZE-1:0] out_data_q [NBANK];
    logic [CL_SIZE-1:0] out_data_d [NBANK];
    logic [2:0]         out_op_q   [NBANK];
    logic [2:0]         out_op_d   [NBANK];
    logic [1:0]         out_src_q  [NBANK];
    logic [1:0]         out_src_d  [NBANK];
    logic [1:0]         out_dest_q [NBANK];
    logic [1:0]         out_dest_d [NBANK];

    // First candidate strictly after 'last' in ic -> dc -> mem -> ic order.
    // Scanning from the farthest distance down lets the nearest one win.
    function automatic logic [1:0] rr_pick(input logic [1:0]      last,
                                           input logic [NSRC-1:0] c);
        logic [1:0] pick;
        logic [1:0] s;
        pick = last;
        for (int k = NSRC; k >= 1; k--) begin
            s = 2'((int'(last) + k) % NSRC);
            if (c[s]) begin
                pick = s;
            end
        end
        return pick;
    endfunction

    // ------------------------------------------------------------------
    // Input packing
    // ------------------------------------------------------------------
    always_comb begin
        in_valid    = {mem_req_valid, dc_req_valid, ic_req_valid};
        in_entry[0] = {ic_req_addr,  ic_req_data,  ic_req_op,  ic_req_dest};
        in_entry[1] = {dc_req_addr,  dc_req_data,  dc_req_op,  dc_req_dest};
        in_entry[2] = {mem_req_addr, mem_req_data, mem_req_op, mem_req_dest};
    end

    assign ic_req_ready  = in_ready[C_IDX_IC];
    assign dc_req_ready  = in_ready[C_IDX_DC];
    assign mem_req_ready = in_ready[C_IDX_MEM];

    // ------------------------------------------------------------------
    // FIFO status and head decode
    // ------------------------------------------------------------------
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            // Ready comes from the registered count only, so a full FIFO
            // stays not-ready even in the cycle its head pops. It is also
            // forced low while reset is held.
            in_ready[s]   = rst && (count_q[s] < CNT_W'(FIFO_DEPTH));
            // NOOP requests complete the handshake but are dropped.
            push[s]       = in_valid[s] && in_ready[s] && (in_entry[s].op != C_OP_NOOP);
            nonempty[s]   = (count_q[s] != '0);
            head_entry[s] = fifo_mem_q[s][rptr_q[s]];
            head_odd[s]   = head_entry[s].addr[4];
        end
    end

    // ------------------------------------------------------------------
    // Per-bank arbitration. A head targets exactly one bank, so a source
    // can never be granted by both banks in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            for (int s = 0; s < NSRC; s++) begin
                cand[b][s] = nonempty[s] && (head_odd[s] == (b == 1));
            end
            gnt_any[b]  = |cand[b];
            gnt_idx[b]  = rr_pick(rr_ptr_q[b], cand[b]);
            rr_ptr_d[b] = gnt_any[b] ? gnt_idx[b] : rr_ptr_q[b];
`ifdef DIR_ARB_MEM_PRIO_EN
            // mem overrides the rotation and leaves the pointer where the
            // last ic/dc grant put it, so ic/dc fairness is preserved.
            if (cand[b][C_IDX_MEM]) begin
                gnt_idx[b]  = C_IDX_MEM;
                rr_ptr_d[b] = rr_ptr_q[b];
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Pop decode and FIFO pointer / count update
    // ------------------------------------------------------------------
    always_comb begin
        for (int s = 0; s < NSRC; s++) begin
            pop[s] = (gnt_any[0] && (gnt_idx[0] == 2'(s))) ||
                     (gnt_any[1] && (gnt_idx[1] == 2'(s)));

            count_d[s] = count_q[s];
            if (push[s] && !pop[s]) begin
                count_d[s] = count_q[s] + CNT_W'(1);
            end else if (pop[s] && !push[s]) begin
                count_d[s] = count_q[s] - CNT_W'(1);
            end

            // Depth is a power of two, so natural overflow wraps the pointers.
            wptr_d[s] = push[s] ? (wptr_q[s] + PTR_W'(1)) : wptr_q[s];
            rptr_d[s] = pop[s]  ? (rptr_q[s] + PTR_W'(1)) : rptr_q[s];
        end
    end

    // ------------------------------------------------------------------
    // Bank output next-state: load the granted head, otherwise drop op to
    // NOOP and hold the remaining fields.
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < NBANK; b++) begin
            out_addr_d[b] = out_addr_q[b];
            out_data_d[b] = out_data_q[b];
            out_src_d[b]  = out_src_q[b];
            out_dest_d[b] = out_dest_q[b];
            out_op_d[b]   = C_OP_NOOP;
            if (gnt_any[b]) begin
                out_addr_d[b] = head_entry[gnt_idx[b]].addr;
                out_data_d[b] = head_entry[gnt_idx[b]].data;
                out_op_d[b]   = head_entry[gnt_idx[b]].op;
                out_dest_d[b] = head_entry[gnt_idx[b]].dest;
                out_src_d[b]  = gnt_idx[b] + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage: write-only on push, no reset needed since validity is
    // tracked entirely by the counters.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSRC; s++) begin
            if (push[s]) begin
                fifo_mem_q[s][wptr_q[s]] <= in_entry[s];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NSRC; s++) begin
                count_q[s] <= '0;
                rptr_q[s]  <= '0;
                wptr_q[s]  <= '0;
            end
            for (int b = 0; b < NBANK; b++) begin
                // Pointer at mem makes ic the first choice after reset.
                rr_ptr_q[b]   <= C_IDX_MEM;
                out_addr_q[b] <= '0;
                out_data_q[b] <= '0;
                out_op_q[b]   <= '0;
                out_src_q[b]  <= '0;
                out_dest_q[b] <= '0;
            end
        end else begin
            for (int s = 0; s < NSRC; s++) begin
                count_q[s] <= count_d[s];
                rptr_q[s]  <= rptr_d[s];
                wptr_q[s]  <= wptr_d[s];
            end
            for (int b = 0; b < NBANK; b++) begin
                rr_ptr_q[b]   <= rr_ptr_d[b];
                out_addr_q[b] <= out_addr_d[b];
                out_data_q[b] <= out_data_d[b];
                out_op_q[b]   <= out_op_d[b];
                out_src_q[b]  <= out_src_d[b];
                out_dest_q[b] <= out_dest_d[b];
            end
        end
    end

    assign even_addr_out = out_addr_q[0];
    assign even_data_out = out_data_q[0];
    assign even_op_out   = out_op_q[0];
    assign even_src_out  = out_src_q[0];
    assign even_dest_out = out_dest_q[0];

    assign odd_addr_out  = out_addr_q[1];
    assign odd_data_out  = out_data_q[1];
    assign odd_op_out    = out_op_q[1];
    assign odd_src_out   = out_src_q[1];
    assign odd_dest_out  = out_dest_q[1];

endmodule
`default_nettype wire

// File: tb/tb_directory_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_directory_req_arbiter
// Purpose  : Self-checking bench for directory_req_arbiter. A queue-based
//            reference model predicts ready and both bank ports every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_directory_req_arbiter;

    localparam int CL    = 128;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0]   addr;
        logic [CL-1:0] data;
        logic [2:0]    op;
        logic [1:0]    dest;
    } ent_t;

    logic          clk;
    logic          rst;
    logic [2:0]    v;
    logic [2:0]    rdy;
    logic [31:0]   a   [3];
    logic [CL-1:0] d   [3];
    logic [2:0]    op  [3];
    logic [1:0]    dst [3];

    logic [31:0]   o_addr [2];
    logic [CL-1:0] o_data [2];
    logic [2:0]    o_op   [2];
    logic [1:0]    o_src  [2];
    logic [1:0]    o_dest [2];

    directory_req_arbiter #(.CL_SIZE(CL), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req_valid  (v[0]),   .ic_req_ready  (rdy[0]), .ic_req_addr  (a[0]),
        .ic_req_data   (d[0]),   .ic_req_op     (op[0]),  .ic_req_dest  (dst[0]),
        .dc_req_valid  (v[1]),   .dc_req_ready  (rdy[1]), .dc_req_addr  (a[1]),
        .dc_req_data   (d[1]),   .dc_req_op     (op[1]),  .dc_req_dest  (dst[1]),
        .mem_req_valid (v[2]),   .mem_req_ready (rdy[2]), .mem_req_addr (a[2]),
        .mem_req_data  (d[2]),   .mem_req_op    (op[2]),  .mem_req_dest (dst[2]),
        .even_addr_out (o_addr[0]), .even_data_out (o_data[0]), .even_op_out (o_op[0]),
        .even_src_out  (o_src[0]),  .even_dest_out (o_dest[0]),
        .odd_addr_out  (o_addr[1]), .odd_data_out  (o_data[1]), .odd_op_out  (o_op[1]),
        .odd_src_out   (o_src[1]),  .odd_dest_out  (o_dest[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    ent_t       mq [3][$];       // pending requests per source, oldest first
    int         last_g [2];      // last source each bank granted (0 ic,1 dc,2 mem)
    ent_t       exp_e  [2];
    logic [2:0] exp_op [2];
    logic [1:0] exp_src[2];
    bit         hs [3];          // handshake seen at the most recent edge
    int         n_pushed;
    int         n_issued_dut;
    int         src_hits [4];    // even-port issues per source code
    int         n_chk, n_pass, n_fail;

    function automatic void model_reset();
        for (int s = 0; s < 3; s++) mq[s].delete();
        for (int b = 0; b < 2; b++) begin
            last_g[b]       = 2;
            exp_e[b].addr   = '0;
            exp_e[b].data   = '0;
            exp_e[b].op     = '0;
            exp_e[b].dest   = '0;
            exp_op[b]       = '0;
            exp_src[b]      = '0;
        end
    endfunction

    // Which source bank b grants this cycle, or -1.
    function automatic int pick(input int b);
        bit c [3];
        int g;
        int s;
        g = -1;
        for (int i = 0; i < 3; i++)
            c[i] = (mq[i].size() > 0) && (int'(mq[i][0].addr[4]) == b);
`ifdef DIR_ARB_MEM_PRIO_EN
        if (c[2]) return 2;
`endif
        for (int k = 1; k <= 3; k++) begin
            s = (last_g[b] + k) % 3;
            if (c[s] && g < 0) g = s;
        end
        return g;
    endfunction

    task automatic drive(input int s, input logic vv, input logic [31:0] addr, input logic [2:0] o);
        v[s]   = vv;
        a[s]   = addr;
        op[s]  = o;
        dst[s] = 2'($urandom_range(1, 3));
        d[s]   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock: check ready, advance model and DUT, check both bank ports.
    task automatic step();
        int   g  [2];
        bit   er [3];
        ent_t e;
        for (int s = 0; s < 3; s++) begin
            er[s] = (mq[s].size() < DEPTH);
            n_chk++;
            if (rdy[s] !== er[s]) begin
                n_fail++;
                $display("FAIL ready src%0d: got %b want %b @%0t", s, rdy[s], er[s], $time);
            end else n_pass++;
            hs[s] = v[s] && er[s];
        end
        for (int b = 0; b < 2; b++) g[b] = pick(b);
        @(posedge clk);
        for (int b = 0; b < 2; b++) begin
            if (g[b] >= 0) begin
                e          = mq[g[b]].pop_front();
                exp_e[b]   = e;
                exp_op[b]  = e.op;
                exp_src[b] = 2'(g[b] + 1);
`ifdef DIR_ARB_MEM_PRIO_EN
                if (g[b] != 2) last_g[b] = g[b];
`else
                last_g[b] = g[b];
`endif
            end else begin
                exp_op[b] = 3'd0;
            end
        end
        for (int s = 0; s < 3; s++) begin
            if (hs[s] && op[s] != 3'd0) begin
                e.addr = a[s]; e.data = d[s]; e.op = op[s]; e.dest = dst[s];
                mq[s].push_back(e);
                n_pushed++;
            end
        end
        #1;
        for (int b = 0; b < 2; b++) begin
            n_chk++;
            if (o_op[b] !== exp_op[b] || o_src[b] !== exp_src[b] || o_addr[b] !== exp_e[b].addr ||
                o_dest[b] !== exp_e[b].dest || o_data[b] !== exp_e[b].data) begin
                n_fail++;
                $display("FAIL bank%0d port: got op=%0d src=%0d addr=%h dest=%0d want op=%0d src=%0d addr=%h dest=%0d @%0t",
                         b, o_op[b], o_src[b], o_addr[b], o_dest[b],
                         exp_op[b], exp_src[b], exp_e[b].addr, exp_e[b].dest, $time);
            end else n_pass++;
            if (o_op[b] !== 3'd0) n_issued_dut++;
        end
        if (o_op[0] !== 3'd0) src_hits[int'(o_src[0])]++;
    endtask

    task automatic idle_inputs();
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 32'h0, 3'd0);
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_pushed     = 0;
        n_issued_dut = 0;
    endtask

    // Drain all queued entries, then confirm nothing was lost or duplicated.
    task automatic drain(input string name);
        idle_inputs();
        for (int c = 0; c < 40; c++) step();
        n_chk++;
        if (n_issued_dut !== n_pushed) begin
            n_fail++;
            $display("FAIL %s scoreboard: issued %0d want %0d", name, n_issued_dut, n_pushed);
        end else n_pass++;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #3;
        for (int b = 0; b < 2; b++) begin
            n_chk++;
            if (o_op[b] !== 3'd0 || o_addr[b] !== 32'h0 || o_src[b] !== 2'd0 ||
                o_dest[b] !== 2'd0 || o_data[b] !== '0) begin
                n_fail++;
                $display("FAIL reset bank%0d: got op=%0d addr=%h src=%0d want all zero", b, o_op[b], o_addr[b], o_src[b]);
            end else n_pass++;
        end
        n_chk++;
        if (rdy !== 3'b000) begin n_fail++; $display("FAIL reset ready low: got %b want 000", rdy); end
        else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (rdy !== 3'b111) begin n_fail++; $display("FAIL reset ready high: got %b want 111", rdy); end
        else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        drive(0, 1'b1, 32'h0000_1000, 3'd3);
        step();
        idle_inputs();
        step();
        n_chk++;
        if (o_op[0] !== 3'd3 || o_src[0] !== 2'd1 || o_addr[0] !== 32'h0000_1000 || o_op[1] !== 3'd0) begin
            n_fail++;
            $display("FAIL single issue: got even op=%0d src=%0d addr=%h odd op=%0d want 3 1 00001000 0",
                     o_op[0], o_src[0], o_addr[0], o_op[1]);
        end else n_pass++;
        step();
        n_chk++;
        if (o_op[0] !== 3'd0 || o_op[1] !== 3'd0) begin
            n_fail++;
            $display("FAIL single idle: got even op=%0d odd op=%0d want 0 0", o_op[0], o_op[1]);
        end else n_pass++;
    endtask

    task automatic test_rr_order();
        int want [4];
`ifdef DIR_ARB_MEM_PRIO_EN
        want[0] = 3; want[1] = 1; want[2] = 2; want[3] = 0;
`else
        want[0] = 1; want[1] = 2; want[2] = 3; want[3] = 0;
`endif
        apply_reset();
        drive(0, 1'b1, 32'h100, 3'd3);
        drive(1, 1'b1, 32'h200, 3'd3);
        drive(2, 1'b1, 32'h300, 3'd3);
        step();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if ((want[i] == 0 && o_op[0] !== 3'd0) ||
                (want[i] != 0 && (o_op[0] !== 3'd3 || int'(o_src[0]) != want[i]))) begin
                n_fail++;
                $display("FAIL rr order slot%0d: got op=%0d src=%0d want src %0d", i, o_op[0], o_src[0], want[i]);
            end else n_pass++;
        end
    endtask

    task automatic test_dual_bank();
        apply_reset();
        drive(0, 1'b1, 32'h00, 3'd3);
        drive(1, 1'b1, 32'h10, 3'd4);
        step();
        idle_inputs();
        step();
        n_chk++;
        if (o_op[0] !== 3'd3 || o_src[0] !== 2'd1 || o_op[1] !== 3'd4 || o_src[1] !== 2'd2) begin
            n_fail++;
            $display("FAIL dual bank: got even op=%0d src=%0d odd op=%0d src=%0d want 3 1 4 2",
                     o_op[0], o_src[0], o_op[1], o_src[1]);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        int hits;
        apply_reset();
        hits = 0;
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 32'h0000_0010 + 32'(i << 5), 3'd5);
            step();
            if (i > 0 && o_op[1] === 3'd5 && o_src[1] === 2'd1) hits++;
        end
        idle_inputs();
        step();
        if (o_op[1] === 3'd5) hits++;
        n_chk++;
        if (hits != 6) begin n_fail++; $display("FAIL back_to_back odd issues: got %0d want 6", hits); end
        else n_pass++;
        drain("back_to_back");
    endtask

    task automatic test_stream();
        int seq [3];
        bit saw_low, saw_rise;
        apply_reset();
        saw_low = 0; saw_rise = 0;
        for (int s = 0; s < 3; s++) begin
            seq[s] = 0;
            drive(s, 1'b1, 32'((s + 1) << 28), 3'd3);
        end
        for (int c = 0; c < 60; c++) begin
            if (c == 30) for (int k = 0; k < 4; k++) src_hits[k] = 0;
            step();
            if (rdy[0] === 1'b0) saw_low = 1;
            else if (saw_low) saw_rise = 1;
            for (int s = 0; s < 3; s++) begin
                if (hs[s]) begin
                    seq[s]++;
                    drive(s, 1'b1, 32'((s + 1) << 28) | 32'(seq[s] << 5), 3'd3);
                end
            end
        end
`ifdef DIR_ARB_MEM_PRIO_EN
        n_chk++;
        if (src_hits[3] != 30 || src_hits[1] + src_hits[2] != 0) begin
            n_fail++;
            $display("FAIL stream share: got ic=%0d dc=%0d mem=%0d want 0 0 30", src_hits[1], src_hits[2], src_hits[3]);
        end else n_pass++;
        n_chk++;
        if (!saw_low) begin n_fail++; $display("FAIL stream ic ready: got never-low want low"); end
        else n_pass++;
`else
        n_chk++;
        if (src_hits[1] != 10 || src_hits[2] != 10 || src_hits[3] != 10) begin
            n_fail++;
            $display("FAIL stream share: got ic=%0d dc=%0d mem=%0d want 10 10 10", src_hits[1], src_hits[2], src_hits[3]);
        end else n_pass++;
        n_chk++;
        if (!saw_low || !saw_rise) begin
            n_fail++;
            $display("FAIL stream ic ready toggle: got low=%0d rise=%0d want 1 1", saw_low, saw_rise);
        end else n_pass++;
`endif
        drain("stream");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            for (int s = 0; s < 3; s++) drive(s, 1'b1, 32'((s + 1) << 28) | 32'(i << 5), 3'd6);
            step();
        end
        idle_inputs();
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (o_op[0] !== 3'd0 || o_op[1] !== 3'd0 || rdy !== 3'b000) begin
            n_fail++;
            $display("FAIL async reset: got even op=%0d odd op=%0d ready=%b want 0 0 000", o_op[0], o_op[1], rdy);
        end else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL reset release ic ready: got %b want 1", rdy[0]); end
        else n_pass++;
        for (int c = 0; c < 5; c++) begin
            step();
            n_chk++;
            if (o_op[0] !== 3'd0 || o_op[1] !== 3'd0) begin
                n_fail++;
                $display("FAIL stale after reset: got even op=%0d odd op=%0d want 0 0", o_op[0], o_op[1]);
            end else n_pass++;
        end
    endtask

    task automatic test_noop();
        apply_reset();
        drive(0, 1'b1, 32'h0000_0040, 3'd0);
        n_chk++;
        if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL noop handshake ready: got %b want 1", rdy[0]); end
        else n_pass++;
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            n_chk++;
            if (o_op[0] !== 3'd0 || o_op[1] !== 3'd0) begin
                n_fail++;
                $display("FAIL noop dropped: got even op=%0d odd op=%0d want 0 0", o_op[0], o_op[1]);
            end else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0] ops [7];
        ops[0] = 3'd0; ops[1] = 3'd2; ops[2] = 3'd3; ops[3] = 3'd4;
        ops[4] = 3'd5; ops[5] = 3'd6; ops[6] = 3'd7;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 3; s++)
                drive(s, 1'($urandom_range(0, 2) != 0), $urandom, ops[$urandom_range(0, 6)]);
            step();
        end
        drain("random");
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        n_pushed = 0; n_issued_dut = 0;
        for (int k = 0; k < 4; k++) src_hits[k] = 0;
        v = 3'b000;
        for (int s = 0; s < 3; s++) begin a[s] = '0; d[s] = '0; op[s] = '0; dst[s] = '0; end
        test_reset();
        test_single();
        test_rr_order();
        test_dual_bank();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        test_noop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
